// File: rtl/checker_pkg.sv
// checker_pkg: scan FSM states, host-memory widths and the checksum fold shared by the page scanner.
package checker_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} scan_state_e;
  localparam int HM_OFFSET_W   = 12;
  localparam int HM_WORD_BYTES = 8;
  localparam int HM_ADDR_W     = 64;
  function automatic logic [63:0] rotxor(input logic [63:0] cs, input logic [63:0] data);
    return {cs[62:0], cs[63]} ^ data;
  endfunction
endpackage

// File: rtl/checker_scan_accum.sv
// checker_scan_accum: checksum register and good-word counter with clear/update strobes.
module checker_scan_accum
  import checker_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic        upd_i,
  input  logic [63:0] data_i,
  output logic [63:0] checksum_o,
  output logic [9:0]  words_o
);
  logic [63:0] cs_q, cs_d;
  logic [9:0]  words_q, words_d;
  always_comb begin
    cs_d    = clr_i ? '0 : upd_i ? rotxor(cs_q, data_i) : cs_q;
    words_d = clr_i ? '0 : upd_i ? words_q + 10'd1 : words_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cs_q    <= '0;
      words_q <= '0;
    end else if (en_i) begin
      cs_q    <= cs_d;
      words_q <= words_d;
    end
  end
  assign checksum_o = cs_q;
  assign words_o    = words_q;
endmodule

// File: rtl/checker_page_scanner.sv
// checker_page_scanner: issues one host-memory read per word of a page run, with retry and checksum.
// Define CHECKER_SCAN_WATCHDOG_EN to add a local response watchdog that acts as a timeout.
module checker_page_scanner
  import checker_pkg::*;
#(
  parameter int MAX_RETRY   = 3,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   en,
  input  logic                   scan_start,
  input  logic [HM_ADDR_W-1:0]   scan_page_addr,
  input  logic [HM_OFFSET_W-1:0] scan_first_offset,
  input  logic [9:0]             scan_nwords,
  output logic                   scan_busy,
  output logic                   scan_done,
  output logic                   scan_error,
  output logic [63:0]            scan_checksum,
  output logic [9:0]             scan_words,
  output logic                   hm_start,
  output logic [HM_ADDR_W-1:0]   hm_page_addr,
  output logic [HM_OFFSET_W-1:0] hm_page_offset,
  input  logic                   hm_end,
  input  logic [63:0]            hm_data,
  input  logic                   hm_timeout
);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  scan_state_e            state_q, state_d;
  logic [HM_ADDR_W-1:0]   addr_q, addr_d;
  logic [HM_OFFSET_W-1:0] off_q, off_d;
  logic [9:0]             rem_q, rem_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic                   err_q, err_d;
  logic                   clr, upd, to_eff;
`ifdef CHECKER_SCAN_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_q, wdog_d;
  // Counting only in WAIT means the counter is already zero on every entry to WAIT.
  always_comb wdog_d = (state_q == S_WAIT) ? wdog_q + WW'(1) : '0;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) wdog_q <= '0;
    else if (en) wdog_q <= wdog_d;
  end
  assign to_eff = hm_timeout | (wdog_q == WW'(WDOG_CYCLES - 1));
`else
  assign to_eff = hm_timeout;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    off_d   = off_q;
    rem_d   = rem_q;
    retry_d = retry_q;
    err_d   = err_q;
    clr     = 1'b0;
    upd     = 1'b0;
    case (state_q)
      S_IDLE: if (scan_start) begin
        addr_d  = scan_page_addr;
        off_d   = scan_first_offset & 12'hFF8;
        rem_d   = (scan_nwords == '0) ? 10'd512 : scan_nwords;
        retry_d = '0;
        err_d   = 1'b0;
        clr     = 1'b1;
        state_d = S_REQ;
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: if (hm_end) begin
        upd     = 1'b1;
        rem_d   = rem_q - 10'd1;
        retry_d = '0;
        off_d   = (rem_q == 10'd1) ? off_q : off_q + HM_OFFSET_W'(HM_WORD_BYTES);
        state_d = (rem_q == 10'd1) ? S_DONE : S_REQ;
      end else if (to_eff) begin
        err_d   = (retry_q == RW'(MAX_RETRY));
        retry_d = err_d ? retry_q : retry_q + RW'(1);
        state_d = err_d ? S_DONE : S_REQ;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      rem_q   <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      rem_q   <= rem_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end
  checker_scan_accum u_accum (
    .clk_i      (sys_clk),
    .rst_ni     (sys_rst_n),
    .en_i       (en),
    .clr_i      (clr),
    .upd_i      (upd),
    .data_i     (hm_data),
    .checksum_o (scan_checksum),
    .words_o    (scan_words)
  );
  assign scan_busy      = (state_q != S_IDLE);
  assign scan_done      = (state_q == S_DONE);
  assign scan_error     = scan_done & err_q;
  assign hm_start       = (state_q == S_REQ);
  assign hm_page_addr   = addr_q;
  assign hm_page_offset = off_q;
endmodule
